wave_loop_fifo: RTL and testbench

WAVE_LOOP_FIFO -- requirements
Module: wave_loop_fifo

---
 rtl/rfsoc_config.sv | 19 +
 rtl/wave_sdp_ram.sv | 52 +++++
 rtl/wave_loop_fifo.sv | 195 +++++++++++++++++++
 tb/tb_wave_loop_fifo.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rfsoc_config.sv
// ---------------------------------------------------------------------------
// rfsoc_config
// Shared RFSoC waveform-path configuration: default word width, default
// waveform FIFO depth and the write-source select encoding.
// ---------------------------------------------------------------------------
package rfsoc_config;

   // One DAC cycle of samples per stored word.
   localparam int unsigned DATA_W_DEF = 256;
   // Default waveform storage depth in words.
   localparam int unsigned DEPTH_DEF  = 1024;

   // FIFO write source select.
   typedef enum logic {
      MUX_LOAD = 1'b0,
      MUX_LOOP = 1'b1
   } mux_sel_e;

endpackage

// File: rtl/wave_sdp_ram.sv
// ---------------------------------------------------------------------------
// wave_sdp_ram
// Single-clock simple dual-port RAM: one write port, one read port with a
// registered output. Array contents are never reset; only the read register is.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset (read register only)
//   wr_en_i    in   write strobe
//   wr_addr_i  in   write address
//   wr_data_i  in   write data
//   rd_en_i    in   read strobe; rd_data_o updates the following cycle
//   rd_addr_i  in   read address
//   rd_data_o  out  registered read data, held while rd_en_i = 0
// ---------------------------------------------------------------------------
module wave_sdp_ram #(
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned DATA_W = 256,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Storage array, no reset.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wave_loop_fifo.sv
// ---------------------------------------------------------------------------
// wave_loop_fifo
// First-word-fall-through waveform FIFO feeding the DAC control stage. Words
// are loaded from the PS, or, in loopback mode, every popped word is written
// back to the tail so a stored waveform plays out endlessly.
//
// Optional build macro: WAVE_LOOP_FIFO_STATS_EN enables the sticky
// overflow/underflow flags and the pop counter; without it those outputs
// are tied to 0.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   s_load_*          PS load stream (tdata/tvalid in, tready out)
//   mux_sel           write source: 0 = load, 1 = loopback
//   loopback_valid    rewrite popped words to the tail (mux_sel = 1)
//   clear             flush pointers/status next cycle
//   m_axis_*          head word stream to the DAC stage
//   level, full, empty         occupancy
//   overflow, underflow        sticky error flags
//   pop_count         words popped since reset or clear
// ---------------------------------------------------------------------------
module wave_loop_fifo
   import rfsoc_config::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_load_tdata,
   input  logic              s_load_tvalid,
   output logic              s_load_tready,
   input  logic              mux_sel,
   input  logic              loopback_valid,
   input  logic              clear,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic [LVL_W-1:0]  level,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow,
   output logic [31:0]       pop_count
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;  // next RAM address to prefetch
   logic [LVL_W-1:0]  level_q, level_d;
   logic              valid_q, valid_d;    // RAM read register holds the head
   logic              full_q, full_d;
   logic              empty_q, empty_d;

   logic              load_mode;
   logic              push_load;
   logic              pop;
   logic              loop_wr;
   logic              fetch;
   logic [PTR_W-1:0]  avail;
   logic              ram_wr_en;
   logic [DATA_W-1:0] ram_wr_data;
   logic [DATA_W-1:0] ram_rd_data;

   assign load_mode     = (mux_sel == MUX_LOAD);
   assign s_load_tready = !full_q && load_mode && !clear && !rst;
   assign push_load     = s_load_tvalid && s_load_tready;
   assign pop           = valid_q && m_axis_tready;
   assign loop_wr       = pop && (mux_sel == MUX_LOOP) && loopback_valid && !clear;

   // Words in RAM not yet moved into the read register. A word written this
   // cycle is not counted, so a read never targets the address being written.
   assign avail = wr_ptr_q - rd_ptr_q;

   // Refill the head whenever it is empty or leaving this cycle.
   assign fetch = (avail != '0) && (!valid_q || pop) && !clear;

   assign ram_wr_en   = push_load || loop_wr;
   assign ram_wr_data = loop_wr ? ram_rd_data : s_load_tdata;

   wave_sdp_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (ram_wr_en),
      .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
      .wr_data_i (ram_wr_data),
      .rd_en_i   (fetch),
      .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
      .rd_data_o (ram_rd_data)
   );

   // Pointer, head-valid and occupancy next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      valid_d  = valid_q;
      level_d  = level_q;

      if (ram_wr_en) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (fetch) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         valid_d  = 1'b1;
      end else if (pop) begin
         valid_d  = 1'b0;
      end

      // Loopback pops and load push+pop leave the level unchanged.
      if (push_load && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push_load && !loop_wr) begin
         level_d = level_q - LVL_W'(1);
      end

      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         valid_d  = 1'b0;
         level_d  = '0;
      end

      full_d  = (level_d == LVL_W'(DEPTH));
      empty_d = (level_d == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         valid_q  <= 1'b0;
         level_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         valid_q  <= valid_d;
         level_q  <= level_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign m_axis_tdata  = ram_rd_data;
   assign m_axis_tvalid = valid_q;
   assign level         = level_q;
   assign full          = full_q;
   assign empty         = empty_q;

`ifdef WAVE_LOOP_FIFO_STATS_EN
   logic        overflow_q, overflow_d;
   logic        underflow_q, underflow_d;
   logic [31:0] pop_count_q, pop_count_d;

   // Sticky error flags and free-running pop counter.
   always_comb begin
      overflow_d  = overflow_q || (s_load_tvalid && full_q && load_mode);
      underflow_d = underflow_q || (m_axis_tready && !valid_q);
      pop_count_d = pop_count_q + 32'(pop);
      if (clear) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
         pop_count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         pop_count_q <= '0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         pop_count_q <= pop_count_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
   assign pop_count = pop_count_q;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
   assign pop_count = '0;
`endif

endmodule

// File: tb/tb_wave_loop_fifo.sv
// ---------------------------------------------------------------------------
// tb_wave_loop_fifo
// Scoreboard bench for wave_loop_fifo at DEPTH = 8. Loaded words are queued
// as they are driven; the monitor pops and compares on every handshake and
// re-queues words in loopback mode.
// ---------------------------------------------------------------------------
module tb_wave_loop_fifo;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned DATA_W = 256;
   localparam int unsigned LVL_W  = $clog2(DEPTH) + 1;
`ifdef WAVE_LOOP_FIFO_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [DATA_W-1:0] s_load_tdata;
   logic              s_load_tvalid;
   logic              s_load_tready;
   logic              mux_sel;
   logic              loopback_valid;
   logic              clear;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic [LVL_W-1:0]  level;
   logic              full;
   logic              empty;
   logic              overflow;
   logic              underflow;
   logic [31:0]       pop_count;

   int n_checks  = 0;
   int n_errors  = 0;
   int pops_seen = 0;
   logic [DATA_W-1:0] exp_q [$];

   wave_loop_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .s_load_tdata   (s_load_tdata),
      .s_load_tvalid  (s_load_tvalid),
      .s_load_tready  (s_load_tready),
      .mux_sel        (mux_sel),
      .loopback_valid (loopback_valid),
      .clear          (clear),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .level          (level),
      .full           (full),
      .empty          (empty),
      .overflow       (overflow),
      .underflow      (underflow),
      .pop_count      (pop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got,
                      input logic [DATA_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one load beat for one cycle; queue it if it should be accepted.
   task automatic load_word(input logic [DATA_W-1:0] d, input bit accept);
      s_load_tvalid = 1'b1;
      s_load_tdata  = d;
      if (accept) exp_q.push_back(d);
      tick();
   endtask

   task automatic wait_empty(input string tag);
      for (int i = 0; i < 40; i++) begin
         if (empty && !m_axis_tvalid) break;
         tick();
      end
      chk(tag, 256'(empty), 256'(1));
   endtask

   // Scoreboard monitor: a handshake seen mid-cycle completes at the next edge.
   always @(negedge clk) begin
      if (rst || clear) begin
         exp_q.delete();
      end else if (m_axis_tvalid && m_axis_tready) begin
         if (exp_q.size() == 0) begin
            chk("sb_extra_pop", 256'(m_axis_tvalid), 256'(0));
         end else begin
            logic [DATA_W-1:0] e;
            e = exp_q.pop_front();
            chk("sb_data", m_axis_tdata, e);
            pops_seen++;
            if (mux_sel && loopback_valid) exp_q.push_back(e);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1);
   end

   initial begin
      logic [DATA_W-1:0] wa, wb, wc, wx;
      wa = {8{32'hAAAA_0001}};
      wb = {8{32'hBBBB_0002}};
      wc = {8{32'hCCCC_0003}};
      wx = {8{32'h5A5A_00EE}};

      rst            = 1'b1;
      s_load_tdata   = '0;
      s_load_tvalid  = 1'b0;
      mux_sel        = 1'b0;
      loopback_valid = 1'b0;
      clear          = 1'b0;
      m_axis_tready  = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
      chk("rst_tdata",  m_axis_tdata,        256'(0));
      chk("rst_level",  256'(level),         256'(0));
      chk("rst_full",   256'(full),          256'(0));
      chk("rst_empty",  256'(empty),         256'(1));
      chk("rst_tready", 256'(s_load_tready), 256'(0));
      chk("rst_ovf",    256'(overflow),      256'(0));
      chk("rst_udf",    256'(underflow),     256'(0));
      chk("rst_popcnt", 256'(pop_count),     256'(0));
      rst = 1'b0;

      // Four loads with tready held high: latency 2, then back-to-back output
      m_axis_tready = 1'b1;
      pops_seen = 0;
      load_word(256'(1), 1'b1);
      chk("t1_tvalid_n1", 256'(m_axis_tvalid), 256'(0));
      chk("t1_level_n1",  256'(level),         256'(1));
      load_word(256'(2), 1'b1);
      chk("t1_tvalid_n2", 256'(m_axis_tvalid), 256'(1));
      chk("t1_head",      m_axis_tdata,        256'(1));
      load_word(256'(3), 1'b1);
      chk("t1_tvalid_n3", 256'(m_axis_tvalid), 256'(1));
      load_word(256'(4), 1'b1);
      chk("t1_tvalid_n4", 256'(m_axis_tvalid), 256'(1));
      s_load_tvalid = 1'b0;
      tick();
      chk("t1_tvalid_n5", 256'(m_axis_tvalid), 256'(1));
      tick();
      chk("t1_empty", 256'(empty), 256'(1));
      chk("t1_level", 256'(level), 256'(0));
      chk("t1_pops",  256'(pops_seen), 256'(4));

      // Fill to DEPTH, ninth load dropped
      m_axis_tready = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t2_clr_level", 256'(level), 256'(0));
      for (int i = 0; i < 9; i++) begin
         load_word(256'(32'h100 + i), i < 8);
         if (i == 6) begin
            chk("t2_full_at7",   256'(full),          256'(0));
            chk("t2_tready_at7", 256'(s_load_tready), 256'(1));
         end
         if (i == 7) begin
            chk("t2_full_at8",   256'(full),          256'(1));
            chk("t2_tready_at8", 256'(s_load_tready), 256'(0));
         end
      end
      s_load_tvalid = 1'b0;
      chk("t2_level", 256'(level),    256'(8));
      chk("t2_full",  256'(full),     256'(1));
      chk("t2_ovf",   256'(overflow), 256'(STATS_ON));
      pops_seen = 0;
      m_axis_tready = 1'b1;
      wait_empty("t2_drain");
      chk("t2_pops", 256'(pops_seen), 256'(8));
      m_axis_tready = 1'b0;

      // Loopback replay of A,B,C
      clear = 1'b1;
      tick();
      clear = 1'b0;
      load_word(wa, 1'b1);
      load_word(wb, 1'b1);
      load_word(wc, 1'b1);
      s_load_tvalid = 1'b0;
      tick();
      tick();
      chk("t3_level0", 256'(level),         256'(3));
      chk("t3_tvalid", 256'(m_axis_tvalid), 256'(1));
      mux_sel        = 1'b1;
      loopback_valid = 1'b1;
      #1;
      chk("t3_tready_loop", 256'(s_load_tready), 256'(0));
      pops_seen = 0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         tick();
         chk("t3_level", 256'(level), 256'(3));
      end
      m_axis_tready = 1'b0;
      chk("t3_pops",   256'(pops_seen), 256'(9));
      chk("t3_popcnt", 256'(pop_count), 256'(STATS_ON ? 9 : 0));
      mux_sel        = 1'b0;
      loopback_valid = 1'b0;

      // Drain, underflow on empty, then clear
      m_axis_tready = 1'b1;
      wait_empty("t4_drain");
      tick();
      chk("t4_udf",    256'(underflow), 256'(STATS_ON));
      chk("t4_level",  256'(level),     256'(0));
      chk("t4_popcnt", 256'(pop_count), 256'(STATS_ON ? 12 : 0));
      clear = 1'b1;
      tick();
      chk("t4_clr_tready", 256'(s_load_tready), 256'(0));
      chk("t4_clr_udf",    256'(underflow),     256'(0));
      chk("t4_clr_popcnt", 256'(pop_count),     256'(0));
      clear = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      chk("t4_udf_stays", 256'(underflow), 256'(0));

      // Reset mid-stream at level 5, then a fresh push
      for (int i = 0; i < 6; i++) begin
         load_word(256'(32'h200 + i), 1'b1);
      end
      s_load_tvalid = 1'b0;
      tick();
      tick();
      m_axis_tready = 1'b1;
      tick();
      chk("t5_level",  256'(level),         256'(5));
      chk("t5_tvalid", 256'(m_axis_tvalid), 256'(1));
      rst = 1'b1;
      tick();
      chk("t5_rst_tvalid", 256'(m_axis_tvalid), 256'(0));
      chk("t5_rst_level",  256'(level),         256'(0));
      chk("t5_rst_empty",  256'(empty),         256'(1));
      chk("t5_rst_tdata",  m_axis_tdata,        256'(0));
      rst = 1'b0;
      m_axis_tready = 1'b0;
      load_word(wx, 1'b1);
      s_load_tvalid = 1'b0;
      chk("t5_tvalid_n1", 256'(m_axis_tvalid), 256'(0));
      tick();
      chk("t5_tvalid_n2", 256'(m_axis_tvalid), 256'(1));
      chk("t5_tdata",     m_axis_tdata,        wx);
      m_axis_tready = 1'b1;
      wait_empty("t5_drain");
      m_axis_tready = 1'b0;
      chk("sb_left", 256'(exp_q.size()), 256'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
